// File: rtl/serial_subtractor32.sv
// Multi-cycle 32-bit subtractor: a - b computed as a + ~b + 1, rippling the carry
// through one CHUNK_W-bit slice per clock, with valid/ready on both sides.
module serial_subtractor32 #(
    parameter  int CHUNK_W = 8,
    localparam int DATA_W  = 32,
    localparam int NCHUNK  = DATA_W / CHUNK_W,
    localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] diff_o,
    output logic              borrow_o,
    output logic              ovf_o,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready_o depends on state only, valid_o is held until ready_i.

    if (!(CHUNK_W == 1 || CHUNK_W == 2 || CHUNK_W == 4 ||
          CHUNK_W == 8 || CHUNK_W == 16 || CHUNK_W == 32)) begin : g_bad_chunk
        $error("serial_subtractor32: CHUNK_W must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   diff_q, diff_d;
    logic                borrow_q, borrow_d;
    logic                ovf_q, ovf_d;

    logic [5:0]          lo;
    logic [CHUNK_W-1:0]  a_slice;
    logic [CHUNK_W-1:0]  b_slice;
    logic [CHUNK_W:0]    slice_sum;
    logic                last_slice;

    assign lo         = 6'(idx_q) * 6'(CHUNK_W);
    assign a_slice    = a_q[lo +: CHUNK_W];
    assign b_slice    = b_q[lo +: CHUNK_W];
    assign slice_sum  = {1'b0, a_slice} + {1'b0, ~b_slice} + {{CHUNK_W{1'b0}}, carry_q};
    assign last_slice = (idx_q == IDX_W'(NCHUNK - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                diff_d[lo +: CHUNK_W] = slice_sum[CHUNK_W-1:0];
                carry_d               = slice_sum[CHUNK_W];
                if (last_slice) begin
                    // diff_d already holds the full result once the top slice is merged in.
                    borrow_d = ~slice_sum[CHUNK_W];
                    ovf_d    = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                               (diff_d[DATA_W-1] != a_q[DATA_W-1]);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o     = (state_q == IDLE);
    assign valid_o     = (state_q == DONE);
    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;
    assign ovf_o       = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor32.sv
// Bench for serial_subtractor32: three instances (CHUNK_W = 8, 1, 32) checked
// against an arithmetic reference model through an expected-result queue.
module tb_serial_subtractor32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  valid_i = '0;
  logic [2:0]  ready_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [2:0]  ready_o, valid_o, borrow_o, ovf_o;
  logic [31:0] diff_o [3];
  logic [1:0]  dbg_state [3];

  serial_subtractor32 #(.CHUNK_W(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
    .diff_o(diff_o[0]), .borrow_o(borrow_o[0]), .ovf_o(ovf_o[0]),
    .dbg_state_o(dbg_state[0]));

  serial_subtractor32 #(.CHUNK_W(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
    .diff_o(diff_o[1]), .borrow_o(borrow_o[1]), .ovf_o(ovf_o[1]),
    .dbg_state_o(dbg_state[1]));

  serial_subtractor32 #(.CHUNK_W(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[2]), .ready_o(ready_o[2]),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o[2]), .ready_i(ready_i[2]),
    .diff_o(diff_o[2]), .borrow_o(borrow_o[2]), .ovf_o(ovf_o[2]),
    .dbg_state_o(dbg_state[2]));

  int nch [3] = '{4, 32, 1};

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {diff, borrow, ovf} from plain integer arithmetic.
  function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    longint sd;
    logic   brw, ov;
    logic [31:0] d;
    d   = a - b;
    brw = (a < b);
    sd  = longint'($signed(a)) - longint'($signed(b));
    ov  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {d, brw, ov};
  endfunction

  function automatic logic [33:0] outs(input int inst);
    return {diff_o[inst], borrow_o[inst], ovf_o[inst]};
  endfunction

  // ---------------- driver ----------------
  task automatic accept(input int inst, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!ready_o[inst] && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("idle_ready", 64'(ready_o[inst]), 64'd1);
    a_i = a;
    b_i = b;
    valid_i[inst] = 1'b1;
    exp_q.push_back(ref_sub(a, b));
    @(negedge clk);
    valid_i[inst] = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    check("calc_ready", {62'd0, ready_o[inst], valid_o[inst]}, 64'd0);
  endtask

  task automatic do_op(input int inst, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    logic [33:0] exp;
    accept(inst, a, b);
    lat = 0;
    while (!valid_o[inst] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(nch[inst]));
    exp = exp_q.pop_front();
    check("result", 64'(outs(inst)), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        valid_i[inst] = 1'b1;
        a_i = 32'd9;
        b_i = 32'd9;
      end else begin
        valid_i[inst] = 1'b0;
      end
      @(negedge clk);
      check("hold_out", 64'(outs(inst)), 64'(exp));
      check("hold_hs", {62'd0, ready_o[inst], valid_o[inst]}, 64'b01);
    end
    valid_i[inst] = 1'b0;
    ready_i[inst] = 1'b1;
    @(negedge clk);
    ready_i[inst] = 1'b0;
    check("post_hs", {28'd0, ready_o[inst], valid_o[inst], outs(inst)}, {28'd0, 2'b10, exp});
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dir_a [8] = '{32'd5, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF,
                             32'h0001_0000, 32'h0100_0000, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] dir_b [8] = '{32'd3, 32'd1, 32'd1, 32'hFFFF_FFFF,
                             32'd1, 32'h0000_0100, 32'hFFFF_FFFF, 32'd0};

  initial begin
    #200_000_0;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_out", {28'd0, ready_o[k], valid_o[k], outs(k)}, {28'd0, 2'b10, 34'd0});
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases on the CHUNK_W=8 instance.
    for (int i = 0; i < 8; i++) do_op(0, dir_a[i], dir_b[i], 0);
    // Cross-slice borrow on the 1-bit and 32-bit instances.
    for (int k = 1; k < 3; k++) begin
      do_op(k, dir_a[4], dir_b[4], 0);
      do_op(k, dir_a[5], dir_b[5], 1);
    end

    // Backpressure with an ignored valid_i pulse, then a normal follow-up op.
    do_op(0, 32'd100, 32'd7, 5);
    do_op(0, 32'd7, 32'd100, 0);

    // Reset while slice 2 is in flight.
    accept(0, 32'h1234_5678, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("midrst_out", {28'd0, ready_o[0], valid_o[0], outs(0)}, {28'd0, 2'b10, 34'd0});
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hold", {28'd0, ready_o[0], valid_o[0], outs(0)}, {28'd0, 2'b10, 34'd0});
    do_op(0, 32'd10, 32'd4, 0);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      do_op(0, $urandom, $urandom, $urandom_range(0, 3));
    end
    for (int i = 0; i < 4; i++) begin
      do_op(1, $urandom, $urandom, $urandom_range(0, 2));
      do_op(2, $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
